// File: rtl/imuldiv_mul_resp_formatter_pkg.sv
// Shared definitions for the multiply response formatter: func codes, field
// widths and the low/high product word selection.
package imuldiv_mul_resp_formatter_pkg;

  localparam int FUNC_W = 3;
  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [FUNC_W-1:0] FUNC_MUL  = 3'd0;
  localparam logic [FUNC_W-1:0] FUNC_MULH = 3'd5;

  // MULH takes the upper word; every other func code behaves as MUL.
  function automatic logic [DATA_W-1:0] format_result(
    input logic [FUNC_W-1:0] func,
    input logic [PROD_W-1:0] prod
  );
    logic [DATA_W-1:0] word;
    if (func == FUNC_MULH) begin
      word = prod[PROD_W-1:DATA_W];
    end else begin
      word = prod[DATA_W-1:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/imuldiv_mul_tag_fifo.sv
// In-order func tag FIFO: one entry per multiply in flight, head is the func
// of the oldest outstanding request.
module imuldiv_mul_tag_fifo
  import imuldiv_mul_resp_formatter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  input  logic [FUNC_W-1:0]        enq_data,
  input  logic                     deq_val,
  output logic                     full,
  output logic                     empty,
  output logic [FUNC_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [FUNC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_enq;
  logic              do_deq;

  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign do_enq = enq_val && !full;
  assign do_deq = deq_val && !empty;
  assign head   = mem[rd_ptr];
  assign count  = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

endmodule

// File: rtl/imuldiv_mul_resp_formatter.sv
// Func-aware front end for the pipelined multiplier: forwards operands, tracks
// func per request, and returns the selected 32-bit word through an output register.
module imuldiv_mul_resp_formatter
  import imuldiv_mul_resp_formatter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [FUNC_W-1:0]      req_msg_func,
  input  logic [DATA_W-1:0]      req_msg_a,
  input  logic [DATA_W-1:0]      req_msg_b,
  input  logic                   req_val,
  output logic                   req_rdy,

  output logic [DATA_W-1:0]      mulreq_msg_a,
  output logic [DATA_W-1:0]      mulreq_msg_b,
  output logic                   mulreq_val,
  input  logic                   mulreq_rdy,

  input  logic [PROD_W-1:0]      mulresp_msg_result,
  input  logic                   mulresp_val,
  output logic                   mulresp_rdy,

  output logic [DATA_W-1:0]      resp_msg_result,
  output logic                   resp_val,
  input  logic                   resp_rdy,

  output logic [$clog2(DEPTH):0] tag_count
);

  // Handshakes: a transfer happens on a rising edge where val && rdy; val
  // never depends on rdy of the same interface, and req_rdy never depends on
  // mulresp_* so freeing a tag only reopens the request path a cycle later.

  logic              tag_full;
  logic              tag_empty;
  logic [FUNC_W-1:0] tag_head;
  logic              req_fire;
  logic              capture;
  logic              out_val;
  logic [DATA_W-1:0] out_result;

  assign mulreq_msg_a = req_msg_a;
  assign mulreq_msg_b = req_msg_b;
  assign mulreq_val   = req_val && !tag_full;
  assign req_rdy      = mulreq_rdy && !tag_full;
  assign req_fire     = req_val && req_rdy;

  assign mulresp_rdy  = !out_val || resp_rdy;
  assign capture      = mulresp_val && mulresp_rdy && !tag_empty;

  imuldiv_mul_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_fire),
    .enq_data (req_msg_func),
    .deq_val  (capture),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (tag_head),
    .count    (tag_count)
  );

  // A capture while the old result drains reloads the register in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val    <= 1'b0;
      out_result <= '0;
    end else if (capture) begin
      out_val    <= 1'b1;
      out_result <= format_result(tag_head, mulresp_msg_result);
    end else if (resp_rdy) begin
      out_val    <= 1'b0;
    end
  end

  assign resp_val        = out_val;
  assign resp_msg_result = out_result;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && mulresp_val && tag_empty) begin
      $display("imuldiv_mul_resp_formatter: ERROR mulresp_val with no outstanding tag at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_imuldiv_mul_resp_formatter.sv
// Directed bench for imuldiv_mul_resp_formatter with a behavioural multiplier
// standing in for imuldiv_IntMulPipelined.
module tb_imuldiv_mul_resp_formatter;
  import imuldiv_mul_resp_formatter_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   req_msg_func = '0;
  logic [31:0]  req_msg_a = '0;
  logic [31:0]  req_msg_b = '0;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic [31:0]  mulreq_msg_a;
  logic [31:0]  mulreq_msg_b;
  logic         mulreq_val;
  logic         mulreq_rdy = 1'b1;
  logic [63:0]  mulresp_msg_result = '0;
  logic         mulresp_val = 1'b0;
  logic         mulresp_rdy;
  logic [31:0]  resp_msg_result;
  logic         resp_val;
  logic         resp_rdy = 1'b1;
  logic [CNT_W-1:0] tag_count;

  imuldiv_mul_resp_formatter #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_msg_func       (req_msg_func),
    .req_msg_a          (req_msg_a),
    .req_msg_b          (req_msg_b),
    .req_val            (req_val),
    .req_rdy            (req_rdy),
    .mulreq_msg_a       (mulreq_msg_a),
    .mulreq_msg_b       (mulreq_msg_b),
    .mulreq_val         (mulreq_val),
    .mulreq_rdy         (mulreq_rdy),
    .mulresp_msg_result (mulresp_msg_result),
    .mulresp_val        (mulresp_val),
    .mulresp_rdy        (mulresp_rdy),
    .resp_msg_result    (resp_msg_result),
    .resp_val           (resp_val),
    .resp_rdy           (resp_rdy),
    .tag_count          (tag_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          rsp_cyc_q[$];
  logic [63:0] prod_q[$];

  logic        mul_hold = 1'b0;
  int          req_fire_cnt = 0;
  logic        drv_done = 1'b0;

  logic [2:0]  vf[16];
  logic [31:0] va[16];
  logic [31:0] vb[16];
  logic [31:0] ve[16];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural multiplier ----------------
  logic        m_req_fire, m_rsp_fire;
  logic [31:0] m_a, m_b;
  int          m_cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q.delete();
      mulresp_val = 1'b0;
      mulresp_msg_result = '0;
    end else begin
      m_req_fire = mulreq_val && mulreq_rdy;
      m_rsp_fire = mulresp_val && mulresp_rdy;
      m_a = mulreq_msg_a;
      m_b = mulreq_msg_b;
      m_cyc = cyc;
      #1;
      if (m_rsp_fire && prod_q.size() > 0) begin
        void'(prod_q.pop_front());
        rsp_cyc_q.push_back(m_cyc);
      end
      if (m_req_fire) begin
        prod_q.push_back({{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b});
        req_fire_cnt++;
      end
      mulresp_val = (prod_q.size() > 0) && !mul_hold;
      mulresp_msg_result = (prod_q.size() > 0) ? prod_q[0] : 64'd0;
    end
  end

  // ---------------- response monitor ----------------
  always @(posedge clk) begin
    if (reset && resp_val && resp_rdy) begin
      got_q.push_back(resp_msg_result);
      got_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    req_val = 1'b1;
    req_msg_func = f;
    req_msg_a = a;
    req_msg_b = b;
    #1;
    while (!req_rdy && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (!req_rdy) begin
      failures++;
      $display("FAIL send_accept got req_rdy=%0b required=1 within 300 cycles", req_rdy);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic drive_list(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) idle();
      end
      send(vf[i], va[i], vb[i]);
    end
    idle();
    drv_done = 1'b1;
  endtask

  task automatic load(input int i, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] e);
    vf[i] = f;
    va[i] = a;
    vb[i] = b;
    ve[i] = e;
  endtask

  task automatic wait_got(input int n);
    int guard = 0;
    while (got_q.size() < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    rsp_cyc_q.delete();
    drv_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    mulreq_rdy = 1'b1;
    req_val = 1'b1;
    resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_rdy !== 1'b1) begin failures++; $display("FAIL rst_req_rdy got=%0b exp=1", req_rdy); end
    checks++; if (mulreq_val !== 1'b1) begin failures++; $display("FAIL rst_mulreq_val got=%0b exp=1", mulreq_val); end
    checks++; if (mulresp_rdy !== 1'b1) begin failures++; $display("FAIL rst_mulresp_rdy got=%0b exp=1", mulresp_rdy); end
    checks++; if (resp_val !== 1'b0) begin failures++; $display("FAIL rst_resp_val got=%0b exp=0", resp_val); end
    checks++; if (resp_msg_result !== 32'h0) begin failures++; $display("FAIL rst_resp_msg got=%h exp=00000000", resp_msg_result); end
    checks++; if (tag_count !== '0) begin failures++; $display("FAIL rst_tag_count got=%0d exp=0", tag_count); end
    mulreq_rdy = 1'b0;
    req_val = 1'b0;
    #1;
    checks++; if (req_rdy !== 1'b0) begin failures++; $display("FAIL rst_req_rdy_follow got=%0b exp=0", req_rdy); end
    checks++; if (mulreq_val !== 1'b0) begin failures++; $display("FAIL rst_mulreq_val_follow got=%0b exp=0", mulreq_val); end
    mulreq_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (resp_val !== 1'b0) begin failures++; $display("FAIL post_rst_resp_val got=%0b exp=0", resp_val); end
    checks++; if (req_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_req_rdy got=%0b exp=1", req_rdy); end
  endtask

  task automatic test_mul();
    logic [31:0] got_v, exp_v;
    clear_sb();
    exp_q.push_back(32'h00000018);
    exp_q.push_back(32'hffffffc0);
    send(FUNC_MUL, 32'h00000008, 32'h00000003);
    send(FUNC_MUL, 32'hfffffff8, 32'h00000008);
    idle();
    wait_got(2);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL mul_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      checks++;
      if (got_cyc_q[i] - rsp_cyc_q[i] != 1) begin
        failures++; $display("FAIL mul_latency[%0d] got=%0d exp=1", i, got_cyc_q[i] - rsp_cyc_q[i]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      got_v = got_q.pop_front(); exp_v = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL mul_result got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_mulh();
    logic [31:0] got_v, exp_v;
    clear_sb();
    exp_q.push_back(32'hfdeadbee);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hffffffff);
    send(FUNC_MULH, 32'hdeadbeef, 32'h10000000);
    send(FUNC_MULH, 32'hffffffff, 32'hffffffff);
    send(FUNC_MULH, 32'hfffffff8, 32'h00000008);
    idle();
    wait_got(3);
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL mulh_count got=%0d exp=3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      got_v = got_q.pop_front(); exp_v = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL mulh_result got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_v, exp_v;
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      send((i % 2 == 0) ? FUNC_MUL : FUNC_MULH, 32'h0deadbee, 32'h10000000);
      exp_q.push_back((i % 2 == 0) ? 32'he0000000 : 32'h00deadbe);
    end
    idle();
    wait_got(4);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i + 1 < got_cyc_q.size(); i++) begin
      checks++;
      if (got_cyc_q[i+1] - got_cyc_q[i] != 1) begin
        failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=1", i, got_cyc_q[i+1] - got_cyc_q[i]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      got_v = got_q.pop_front(); exp_v = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL b2b_result got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_v, exp_v;
    int guard = 0;
    clear_sb();
    load(0, FUNC_MUL,  32'h00000002, 32'h00000003, 32'h00000006);
    load(1, FUNC_MULH, 32'hfffffffe, 32'h00000003, 32'hffffffff);
    load(2, FUNC_MUL,  32'h00000007, 32'h00000007, 32'h00000031);
    load(3, FUNC_MULH, 32'h40000000, 32'h00000004, 32'h00000001);
    load(4, FUNC_MUL,  32'hffffffff, 32'h00000005, 32'hfffffffb);
    load(5, FUNC_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    load(6, FUNC_MUL,  32'h00010000, 32'h00010000, 32'h00000000);
    load(7, 3'd2,      32'h00001234, 32'h00000010, 32'h00012340);
    for (int i = 0; i < 8; i++) exp_q.push_back(ve[i]);
    @(negedge clk);
    resp_rdy = 1'b0;
    mul_hold = 1'b1;
    req_fire_cnt = 0;
    fork
      drive_list(8, 1'b0);
    join_none
    repeat (20) @(negedge clk);
    #1;
    checks++; if (req_fire_cnt != DEPTH) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", req_fire_cnt, DEPTH); end
    checks++; if (req_rdy !== 1'b0) begin failures++; $display("FAIL bp_req_rdy got=%0b exp=0", req_rdy); end
    checks++; if (tag_count !== CNT_W'(DEPTH)) begin failures++; $display("FAIL bp_tag_count got=%0d exp=%0d", tag_count, DEPTH); end
    // One product reaches the output register and retires its tag, so a single extra request gets in.
    mul_hold = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (req_fire_cnt != DEPTH + 1) begin failures++; $display("FAIL bp_accepted_parked got=%0d exp=%0d", req_fire_cnt, DEPTH + 1); end
    checks++; if (resp_val !== 1'b1) begin failures++; $display("FAIL bp_resp_val got=%0b exp=1", resp_val); end
    checks++; if (mulresp_rdy !== 1'b0) begin failures++; $display("FAIL bp_mulresp_rdy got=%0b exp=0", mulresp_rdy); end
    checks++; if (req_rdy !== 1'b0) begin failures++; $display("FAIL bp_req_rdy_parked got=%0b exp=0", req_rdy); end
    resp_rdy = 1'b1;
    wait_got(8);
    while (!drv_done && guard < 100) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      got_v = got_q.pop_front(); exp_v = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL bp_result got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_random_delays();
    logic [31:0] got_v, exp_v;
    clear_sb();
    load(0, FUNC_MUL,  32'h00000008, 32'h00000003, 32'h00000018);
    load(1, FUNC_MULH, 32'hdeadbeef, 32'h10000000, 32'hfdeadbee);
    load(2, FUNC_MUL,  32'hfffffff8, 32'h00000008, 32'hffffffc0);
    load(3, FUNC_MULH, 32'hffffffff, 32'hffffffff, 32'h00000000);
    load(4, FUNC_MUL,  32'h0deadbee, 32'h10000000, 32'he0000000);
    load(5, FUNC_MULH, 32'h0deadbee, 32'h10000000, 32'h00deadbe);
    load(6, FUNC_MULH, 32'hfffffff8, 32'h00000008, 32'hffffffff);
    load(7, FUNC_MUL,  32'h00000001, 32'hffffffff, 32'hffffffff);
    load(8, FUNC_MULH, 32'h7fffffff, 32'h7fffffff, 32'h3fffffff);
    load(9, FUNC_MUL,  32'h00001000, 32'h00001000, 32'h01000000);
    for (int i = 0; i < 10; i++) exp_q.push_back(ve[i]);
    fork
      drive_list(10, 1'b1);
      begin
        int hold_left = 0;
        int guard = 0;
        while (got_q.size() < 10 && guard < 600) begin
          @(negedge clk);
          guard++;
          if (hold_left > 0) begin
            resp_rdy = 1'b0;
            hold_left--;
          end else begin
            resp_rdy = 1'b1;
            hold_left = $urandom_range(0, 3);
          end
        end
      end
    join
    resp_rdy = 1'b1;
    checks++; if (got_q.size() != 10) begin failures++; $display("FAIL rnd_count got=%0d exp=10", got_q.size()); end
    for (int i = 0; i < 10 && got_q.size() > 0; i++) begin
      got_v = got_q.pop_front(); exp_v = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rnd_result[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got_v;
    clear_sb();
    @(negedge clk);
    resp_rdy = 1'b0;
    send(FUNC_MUL, 32'h00000002, 32'h00000002);
    send(FUNC_MUL, 32'h00000003, 32'h00000003);
    send(FUNC_MULH, 32'h00000004, 32'h00000004);
    send(FUNC_MUL, 32'h00000005, 32'h00000005);
    idle();
    repeat (4) @(negedge clk);
    #1;
    checks++; if (resp_val !== 1'b1) begin failures++; $display("FAIL mid_held_resp_val got=%0b exp=1", resp_val); end
    checks++; if (tag_count !== CNT_W'(3)) begin failures++; $display("FAIL mid_inflight got=%0d exp=3", tag_count); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (resp_val !== 1'b0) begin failures++; $display("FAIL mid_rst_resp_val got=%0b exp=0", resp_val); end
    checks++; if (tag_count !== '0) begin failures++; $display("FAIL mid_rst_tag_count got=%0d exp=0", tag_count); end
    checks++; if (resp_msg_result !== 32'h0) begin failures++; $display("FAIL mid_rst_resp_msg got=%h exp=00000000", resp_msg_result); end
    checks++; if (mulresp_rdy !== 1'b1) begin failures++; $display("FAIL mid_rst_mulresp_rdy got=%0b exp=1", mulresp_rdy); end
    @(negedge clk);
    reset = 1'b1;
    resp_rdy = 1'b1;
    got_q.delete();
    send(FUNC_MUL, 32'h00000001, 32'hffffffff);
    idle();
    wait_got(1);
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL mid_post_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      got_v = got_q.pop_front();
      checks++; if (got_v !== 32'hffffffff) begin failures++; $display("FAIL mid_post_result got=%h exp=ffffffff", got_v); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_back_to_back();
    test_backpressure();
    test_random_delays();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
